// File: rtl/product_display_scroller.sv
// Converts a 16-bit product to five BCD digits by sequential double-dabble and
// shows a scrollable four-digit window on a multiplexed active-low 7-segment display.
module product_display_scroller #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clkin,
    input  logic        rst,
    input  logic [15:0] product,
    input  logic        product_valid,
    input  logic        scrLeft,
    input  logic        scrRight,
    output logic        busy,
    output logic [6:0]  segments_a_to_g,
    output logic [3:0]  finanode
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t      state, state_next;
    logic [35:0] work, work_next, work_adj, work_shift;
    logic [4:0]  bit_cnt, bit_cnt_next;
    logic        busy_next;
    logic [19:0] digits, digits_next;
    logic        offset, offset_next;

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    sel;
    logic [2:0]    idx;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // work holds {BCD scratch, binary shift}; adjust every scratch nibble, then shift the pair.
    always_comb begin
        work_adj = work;
        for (int i = 0; i < 5; i++) begin
            if (work[16+4*i +: 4] >= 4'd5)
                work_adj[16+4*i +: 4] = work[16+4*i +: 4] + 4'd3;
        end
        work_shift = work_adj << 1;
    end

    always_comb begin
        state_next   = state;
        work_next    = work;
        bit_cnt_next = bit_cnt;
        busy_next    = busy;
        digits_next  = digits;
        offset_next  = offset;

        if (scrLeft && !scrRight)
            offset_next = 1'b1;
        else if (scrRight && !scrLeft)
            offset_next = 1'b0;

        case (state)
            IDLE: begin
                if (product_valid) begin
                    work_next    = {20'd0, product};
                    bit_cnt_next = 5'd16;
                    busy_next    = 1'b1;
                    state_next   = CONVERT;
                end
            end
            CONVERT: begin
                work_next    = work_shift;
                bit_cnt_next = bit_cnt - 5'd1;
                // Commit overrides any scroll pulse arriving in the same cycle.
                if (bit_cnt == 5'd1) begin
                    digits_next = work_shift[35:16];
                    offset_next = 1'b0;
                    busy_next   = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state   <= IDLE;
            work    <= 36'd0;
            bit_cnt <= 5'd0;
            busy    <= 1'b0;
            digits  <= 20'd0;
            offset  <= 1'b0;
        end else begin
            state   <= state_next;
            work    <= work_next;
            bit_cnt <= bit_cnt_next;
            busy    <= busy_next;
            digits  <= digits_next;
            offset  <= offset_next;
        end
    end

    // Blanking looks at the absolute digit index, so scrolling never un-blanks a leading zero.
    always_comb begin
        idx = {1'b0, sel} + {2'b00, offset};
        case (idx)
            3'd0:    nib = digits[3:0];
            3'd1:    nib = digits[7:4];
            3'd2:    nib = digits[11:8];
            3'd3:    nib = digits[15:12];
            3'd4:    nib = digits[19:16];
            default: nib = 4'd0;
        endcase
        blank    = BLANK_LEADING && (idx != 3'd0) && ((digits >> {idx, 2'b00}) == 20'd0);
        seg_next = blank ? 7'b1111111 : seg7(nib);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            refresh_cnt     <= '0;
            sel             <= 2'd0;
            segments_a_to_g <= 7'b1111111;
            finanode        <= 4'b1111;
        end else begin
            if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                sel         <= sel + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CW'(1);
            end
            segments_a_to_g <= seg_next;
            finanode        <= ~(4'b0001 << sel);
        end
    end

endmodule

// File: tb/tb_product_display_scroller.sv
// Self-checking bench: two scrollers (leading-zero blanking on and off) driven in
// parallel and compared against a decimal-arithmetic model of the visible window.
module tb_product_display_scroller;

    localparam int DIV = 4;

    logic        clkin = 1'b0;
    logic        rst;
    logic [15:0] product;
    logic        product_valid;
    logic        scrLeft;
    logic        scrRight;

    logic        busy, busy_nb;
    logic [6:0]  segs, segs_nb;
    logic [3:0]  anode, anode_nb;

    int errors = 0;
    int checks = 0;
    int model_val = 0;
    int model_off = 0;

    logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                  7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    always #5 clkin = ~clkin;

    product_display_scroller #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) dut (
        .clkin(clkin), .rst(rst), .product(product), .product_valid(product_valid),
        .scrLeft(scrLeft), .scrRight(scrRight), .busy(busy),
        .segments_a_to_g(segs), .finanode(anode)
    );

    product_display_scroller #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) dut_nb (
        .clkin(clkin), .rst(rst), .product(product), .product_valid(product_valid),
        .scrLeft(scrLeft), .scrRight(scrRight), .busy(busy_nb),
        .segments_a_to_g(segs_nb), .finanode(anode_nb)
    );

    task automatic tick;
        @(posedge clkin);
        #1;
    endtask

    // Digit idx of v in decimal; blank if it is a leading zero above the units digit.
    function automatic logic [6:0] model_seg(input int v, input int idx, input bit blank_en);
        int p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (blank_en && idx > 0 && v < p) return 7'b1111111;
        return seg_tab[(v / p) % 10];
    endfunction

    function automatic int anode_pos(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check_window(input string name);
        logic [3:0] seen, seen_nb;
        logic [6:0] exp;
        int p;
        seen = 4'b0000;
        seen_nb = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            tick();
            p = anode_pos(anode);
            checks++;
            if (p < 0) begin
                errors++;
                $display("[TB] FAIL %s anode: got %b required one-hot-low", name, anode);
            end else begin
                seen[p] = 1'b1;
                exp = model_seg(model_val, p + model_off, 1'b1);
                checks++;
                if (segs !== exp) begin
                    errors++;
                    $display("[TB] FAIL %s segs pos%0d: got %b required %b", name, p, segs, exp);
                end
            end
            p = anode_pos(anode_nb);
            checks++;
            if (p < 0) begin
                errors++;
                $display("[TB] FAIL %s anode_nb: got %b required one-hot-low", name, anode_nb);
            end else begin
                seen_nb[p] = 1'b1;
                exp = model_seg(model_val, p + model_off, 1'b0);
                checks++;
                if (segs_nb !== exp) begin
                    errors++;
                    $display("[TB] FAIL %s segs_nb pos%0d: got %b required %b", name, p, segs_nb, exp);
                end
            end
        end
        checks++;
        if ({seen, seen_nb} !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL %s sweep: got %b/%b required 1111/1111", name, seen, seen_nb);
        end
    endtask

    task automatic convert(input int v);
        int count;
        product = 16'(v);
        product_valid = 1'b1;
        tick();
        product_valid = 1'b0;
        count = 0;
        while (busy === 1'b1 && count < 40) begin
            count++;
            tick();
        end
        checks++;
        if (count !== 16) begin
            errors++;
            $display("[TB] FAIL busy_len %0d: got %0d required 16", v, count);
        end
        model_val = v;
        model_off = 0;
        tick();
    endtask

    task automatic scroll(input bit l, input bit r);
        scrLeft = l;
        scrRight = r;
        tick();
        scrLeft = 1'b0;
        scrRight = 1'b0;
        if (l && !r) model_off = 1;
        else if (r && !l) model_off = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, busy_nb, anode, anode_nb, segs, segs_nb} !== {2'b00, 8'hFF, 14'h3FFF}) begin
            errors++;
            $display("[TB] FAIL reset: got busy=%b anode=%b segs=%b required 0/1111/1111111",
                     busy, anode, segs);
        end
        rst = 1'b0;
        model_val = 0;
        model_off = 0;
    endtask

    task automatic test_first_product;
        convert(65);
        check_window("p65");
    endtask

    task automatic test_refresh_cadence;
        logic [3:0] prev, exp;
        int p, n;
        prev = anode;
        n = 0;
        while (anode === prev && n < 10) begin
            n++;
            tick();
        end
        p = anode_pos(anode);
        checks++;
        if (p < 0) begin
            errors++;
            $display("[TB] FAIL cadence_start: got %b required one-hot-low", anode);
        end else begin
            for (int k = 0; k < 24; k++) begin
                exp = 4'b1111 ^ (4'b0001 << ((p + k / 4) % 4));
                checks++;
                if (anode !== exp) begin
                    errors++;
                    $display("[TB] FAIL cadence k=%0d: got %b required %b", k, anode, exp);
                end
                tick();
            end
        end
    endtask

    task automatic test_scroll;
        convert(65535);
        check_window("scroll_off0");
        scroll(1'b1, 1'b0);
        check_window("scroll_left");
        scroll(1'b1, 1'b0);
        check_window("scroll_left_sat");
        scroll(1'b1, 1'b1);
        check_window("scroll_both_at1");
        scroll(1'b0, 1'b1);
        check_window("scroll_right");
        scroll(1'b0, 1'b1);
        check_window("scroll_right_sat");
        scroll(1'b1, 1'b1);
        check_window("scroll_both_at0");
    endtask

    task automatic test_back_to_back;
        int p;
        logic [6:0] exp;
        product = 16'd1234;
        product_valid = 1'b1;
        tick();
        product_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        product = 16'd9999;
        product_valid = 1'b1;
        tick();
        product_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        model_val = 1234;
        model_off = 0;
        p = anode_pos(anode);
        exp = (p < 0) ? 7'bxxxxxxx : model_seg(1234, p, 1'b1);
        checks++;
        if (segs !== exp || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_n17: got busy=%b segs=%b required 0/%b", busy, segs, exp);
        end
        check_window("b2b_1234");
    endtask

    task automatic test_abort;
        product = 16'd4321;
        product_valid = 1'b1;
        tick();
        product_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, busy_nb, anode, anode_nb, segs, segs_nb} !== {2'b00, 8'hFF, 14'h3FFF}) begin
            errors++;
            $display("[TB] FAIL abort: got busy=%b anode=%b segs=%b required 0/1111/1111111",
                     busy, anode, segs);
        end
        rst = 1'b0;
        model_val = 0;
        model_off = 0;
        check_window("after_abort");
        convert(0);
        check_window("zero");
    endtask

    task automatic test_no_blank;
        convert(7);
        check_window("seven");
    endtask

    task automatic test_scroll_while_busy;
        convert(54321);
        scroll(1'b1, 1'b0);
        check_window("pre_busy_left");
        product = 16'd12345;
        product_valid = 1'b1;
        tick();
        product_valid = 1'b0;
        tick();
        tick();
        scrLeft = 1'b1;
        tick();
        scrLeft = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        model_val = 12345;
        model_off = 0;
        check_window("busy_scroll_commit");
    endtask

    task automatic test_random;
        int v;
        for (int n = 0; n < 8; n++) begin
            v = int'($urandom_range(0, 65535));
            if (n == 0) v = int'($urandom_range(0, 99));
            convert(v);
            if ($urandom_range(0, 1) == 1) scroll(1'b1, 1'b0);
            check_window($sformatf("rand%0d_%0d", n, v));
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        product = 16'd0;
        product_valid = 1'b0;
        scrLeft = 1'b0;
        scrRight = 1'b0;
        test_reset();
        test_first_product();
        test_refresh_cadence();
        test_scroll();
        test_back_to_back();
        test_abort();
        test_no_blank();
        test_scroll_while_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/product_display_scroller.md
Name: product_display_scroller

Overview:
- Downstream consumer of the 8x8 multiplier state machine: takes the 16-bit product and a one-cycle valid pulse.
- Converts the product to 5 BCD digits sequentially using shift-add-3 (double-dabble).
- Shows a scrollable 4-digit window on a multiplexed, active-low, common-anode 7-segment display.
- Scroll inputs are single-cycle pulses from the upstream button conditioner.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit (about 1 kHz per digit at 100 MHz); minimum 2
BLANK_LEADING, 1, 1 = blank leading zeros; 0 = show all digits

Ports:
clkin  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
product  input  16  unsigned product from multiplier
product_valid  input  1  one-cycle pulse; product is valid in that cycle
scrLeft  input  1  one-cycle pulse; move window toward more-significant digits
scrRight  input  1  one-cycle pulse; move window toward less-significant digits
busy  output  1  high while a conversion is in progress
segments_a_to_g  output  7  active-low segments; bit6=a … bit0=g
finanode  output  4  active-low anode one-hot; bit0 = rightmost digit

Behaviour:
- Clocking and reset:
  - One clock (clkin); reset is synchronous and active-high (rst); all state is registered.
- Reset values:
  - state=IDLE, busy=0, offset=0.
  - Digit registers d4..d0=0, refresh counter=0, digit select=0.
  - finanode=4'b1111, segments_a_to_g=7'b1111111.
  - Outputs take these values on the first clkin edge with rst high.
  - rst overrides everything, including mid-conversion: conversion is aborted and the display is cleared.
- FSM states:
  - IDLE:
    - On product_valid: latch product into shift register, clear BCD scratch (20 bits), set bit counter=16, busy=1, go to CONVERT.
  - CONVERT, once per cycle:
    - Each scratch nibble >=5 gets +3.
    - Then {scratch, shift} shifts left by 1 and the counter decrements.
    - After the 16th shift: copy scratch to d4..d0, set offset=0, busy=0, return to IDLE.
- Timing and handshake:
  - product_valid at edge N → busy high for edges N+1..N+16.
  - New digits are visible from edge N+17.
  - product_valid while busy=1 is ignored; there is no queueing.
  - Displayed digits keep their old value until commit.
- Scroll window:
  - offset ∈ {0,1}. Offset 0 shows d3..d0; offset 1 shows d4..d1.
  - scrLeft: offset goes 0→1; it saturates at 1.
  - scrRight: offset goes 1→0; it saturates at 0.
  - scrLeft and scrRight in the same cycle: no change.
  - Scroll pulses are accepted while busy, but commit forces offset to 0.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1; on wrap, digit select advances 0→1→2→3→0.
  - finanode: select 0→1110, 1→1101, 2→1011, 3→0111.
  - segments_a_to_g and finanode are registered together and change on the same edge.
  - Segment pattern for select s is taken from digit d(s+offset).
- Decode (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
- Blanking (BLANK_LEADING=1):
  - d_i for i>0 is blank when d4..d_i are all zero.
  - d0 is never blanked.
  - The blanking decision is made on the absolute digit index, independent of offset.

Test Plan:
- Reset, then product=65 (13×5) with a valid pulse: busy high exactly 16 cycles; digits=00065. With REFRESH_DIV=4, the anode sweep shows segments blank, blank, 0100000 (6), 0100100 (5) on finanode 0111, 1011, 1101, 1110.
- Refresh cadence at REFRESH_DIV=4: finanode holds each of 1110, 1101, 1011, 0111 for exactly 4 cycles, then repeats.
- product=65535:
  - Offset 0 shows 5535.
  - scrLeft → shows 6553; a second scrLeft → still 6553.
  - scrRight → 5535; a second scrRight → still 5535.
  - scrLeft and scrRight in the same cycle → unchanged.
- product_valid with 1234 at cycle N, then with 9999 at N+5: the second pulse is ignored; the display shows 1234 at N+17.
- rst asserted at cycle 8 of converting 4321: next edge has busy=0, finanode=1111, digits 0; a later pulse of 0 shows a single "0" on the rightmost digit only.
- BLANK_LEADING=0, product=7: the display shows 0007 with all four digits lit.
